// File: rtl/wb_debug_master_pkg.sv
// Shared SoC definitions for the byte-serial Wishbone debug master:
// command opcodes, default response bytes and the FSM state encoding.
package wb_debug_master_pkg;

    localparam logic [7:0] OP_READ      = 8'h52;
    localparam logic [7:0] OP_WRITE     = 8'h57;
    localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/wb_debug_master.sv
// Byte-serial host command to single 16-bit Wishbone read/write bridge,
// answering each command with ACK(+data) or NAK bytes on the host link.
module wb_debug_master
    import wb_debug_master_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [7:0]  NAK_BYTE = DEF_NAK_BYTE,
    parameter logic [7:0]  ACK_BYTE = DEF_ACK_BYTE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_stb_i,
    output logic [7:0]  tx_dat_o,
    output logic        tx_stb_o,
    input  logic        tx_busy_i,
    output logic [31:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r, state_s;
    logic [1:0]  byte_cnt_r;
    logic [7:0]  tmo_cnt_r;
    logic        is_write_r;
    logic        resp_nak_r;
    logic [1:0]  resp_idx_r;
    logic        gap_r;
    logic [15:0] rd_data_r;
    logic [31:0] wb_adr_r;
    logic [15:0] wb_dat_r;
    logic [1:0]  wb_sel_r;
    logic        wb_we_r, wb_cyc_r, wb_stb_r;
    logic [7:0]  tx_dat_r;
    logic        tx_stb_r;
    logic        busy_r;

    logic        valid_op_s, ack_hit_s, tmo_hit_s, emit_s, last_s;
    logic [1:0]  resp_len_s;
    logic [7:0]  resp_byte_s;

    // Bus-cycle and response events plus the byte currently due on the link
    always_comb begin
        valid_op_s  = (rx_dat_i == OP_READ) || (rx_dat_i == OP_WRITE);
        ack_hit_s   = (state_r == ST_BUS) && wb_cyc_r && wb_ack_i;
        tmo_hit_s   = (state_r == ST_BUS) && wb_cyc_r && !wb_ack_i && (tmo_cnt_r == TMO_LAST);
        emit_s      = (state_r == ST_RESP) && !tx_busy_i && !gap_r;
        resp_len_s  = (resp_nak_r || is_write_r) ? 2'd1 : 2'd3;
        last_s      = (resp_idx_r == (resp_len_s - 2'd1));
        case (resp_idx_r)
            2'd0:    resp_byte_s = resp_nak_r ? NAK_BYTE : ACK_BYTE;
            2'd1:    resp_byte_s = rd_data_r[15:8];
            default: resp_byte_s = rd_data_r[7:0];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_stb_i) begin
                    state_s = valid_op_s ? ST_ADDR : ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_stb_i && (byte_cnt_r == 2'd3)) begin
                    state_s = is_write_r ? ST_DATA : ST_BUS;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rx_stb_i && (byte_cnt_r == 2'd1)) begin
                    state_s = ST_BUS;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_BUS: begin
                if (ack_hit_s || tmo_hit_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (emit_s && last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and datapath; gap_r enforces one quiet cycle before each strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 2'd0;
            tmo_cnt_r  <= 8'd0;
            is_write_r <= 1'b0;
            resp_nak_r <= 1'b0;
            resp_idx_r <= 2'd0;
            gap_r      <= 1'b0;
            rd_data_r  <= 16'd0;
            wb_adr_r   <= 32'd0;
            wb_dat_r   <= 16'd0;
            wb_sel_r   <= 2'b00;
            wb_we_r    <= 1'b0;
            wb_cyc_r   <= 1'b0;
            wb_stb_r   <= 1'b0;
            tx_dat_r   <= 8'd0;
            tx_stb_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            busy_r   <= (state_s != ST_IDLE);
            tx_stb_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_stb_i) begin
                        is_write_r <= (rx_dat_i == OP_WRITE);
                        resp_nak_r <= !valid_op_s;
                        byte_cnt_r <= 2'd0;
                        resp_idx_r <= 2'd0;
                        gap_r      <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (rx_stb_i) begin
                        wb_adr_r   <= {wb_adr_r[23:0], rx_dat_i};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_stb_i) begin
                        wb_dat_r   <= {wb_dat_r[7:0], rx_dat_i};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                    end
                end
                ST_BUS: begin
                    if (!wb_cyc_r) begin
                        wb_cyc_r  <= 1'b1;
                        wb_stb_r  <= 1'b1;
                        wb_we_r   <= is_write_r;
                        wb_sel_r  <= 2'b11;
                        tmo_cnt_r <= 8'd0;
                    end else if (ack_hit_s || tmo_hit_s) begin
                        wb_cyc_r   <= 1'b0;
                        wb_stb_r   <= 1'b0;
                        wb_we_r    <= 1'b0;
                        wb_sel_r   <= 2'b00;
                        resp_nak_r <= tmo_hit_s;
                        resp_idx_r <= 2'd0;
                        gap_r      <= 1'b1;
                        if (ack_hit_s && !is_write_r) begin
                            rd_data_r <= wb_dat_i;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (emit_s) begin
                        tx_stb_r   <= 1'b1;
                        tx_dat_r   <= resp_byte_s;
                        resp_idx_r <= resp_idx_r + 2'd1;
                        gap_r      <= 1'b1;
                    end else begin
                        gap_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_dat_o = tx_dat_r;
    assign tx_stb_o = tx_stb_r;
    assign wb_adr_o = wb_adr_r;
    assign wb_dat_o = wb_dat_r;
    assign wb_sel_o = wb_sel_r;
    assign wb_we_o  = wb_we_r;
    assign wb_cyc_o = wb_cyc_r;
    assign wb_stb_o = wb_stb_r;
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_wb_debug_master.sv
// Directed self-checking bench for wb_debug_master (TIMEOUT=8).
module tb_wb_debug_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_dat = 8'd0;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_dat;
    logic        tx_stb;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr;
    logic [15:0] wb_dat_w;
    logic [15:0] wb_dat_r = 16'd0;
    logic [1:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic        wb_ack = 1'b0;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    wb_debug_master #(.TIMEOUT(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .rx_dat_i  (rx_dat),
        .rx_stb_i  (rx_stb),
        .tx_dat_o  (tx_dat),
        .tx_stb_o  (tx_stb),
        .tx_busy_i (tx_busy),
        .wb_adr_o  (wb_adr),
        .wb_dat_o  (wb_dat_w),
        .wb_dat_i  (wb_dat_r),
        .wb_sel_o  (wb_sel),
        .wb_we_o   (wb_we),
        .wb_cyc_o  (wb_cyc),
        .wb_stb_o  (wb_stb),
        .wb_ack_i  (wb_ack),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one strobed byte followed by one quiet cycle
    task automatic send_byte(input logic [7:0] b);
        rx_dat = b;
        rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
        tick();
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        tick();
        while (tx_stb !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, {31'd0, tx_stb}, 32'd1);
        check(tag, {24'd0, tx_dat}, {24'd0, exp});
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (tx_stb === 1'b1) cnt++;
        end
    endtask

    initial begin
        int n;
        // ---------------- reset state
        tick(); tick(); tick();
        check("rst_ctrl", {27'd0, wb_cyc, wb_stb, wb_we, tx_stb, busy}, 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_dat", {wb_dat_w, tx_dat, 6'd0, wb_sel}, 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- read: 52 00 00 10 00, ack in 4th cyc cycle with BEEF
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        rx_dat = 8'h00; rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
        check("rd_cyc_not_yet", {31'd0, wb_cyc}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd1);
        tick();
        check("rd_adr", wb_adr, 32'h0000_1000);
        check("rd_ctrl", {28'd0, wb_sel, wb_we, wb_stb}, 32'b1101);
        for (int i = 0; i < 4; i++) begin
            check("rd_cyc_high", {31'd0, wb_cyc}, 32'd1);
            if (i == 3) begin
                wb_ack = 1'b1;
                wb_dat_r = 16'hBEEF;
            end
            tick();
        end
        wb_ack = 1'b0;
        wb_dat_r = 16'h0000;
        check("rd_after_ack", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
        check("rd_lat0", {31'd0, tx_stb}, 32'd0);
        tick();
        check("rd_lat1", {31'd0, tx_stb}, 32'd0);
        tick();
        check("rd_first_stb", {31'd0, tx_stb}, 32'd1);
        check("rd_b0", {24'd0, tx_dat}, 32'h06);
        wait_tx("rd_b1", 8'hBE);
        wait_tx("rd_b2", 8'hEF);
        check("rd_idle", {31'd0, busy}, 32'd0);
        tick();
        check("rd_one_cycle_stb", {31'd0, tx_stb}, 32'd0);

        // ---------------- write: 57 F0 00 00 00 12 34
        send_byte(8'h57); send_byte(8'hF0); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
        check("wr_adr", wb_adr, 32'hF000_0000);
        check("wr_dat", {16'd0, wb_dat_w}, 32'h1234);
        check("wr_ctrl", {27'd0, wb_sel, wb_we, wb_cyc, wb_stb}, 32'b11111);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("wr_after_ack", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
        wait_tx("wr_b0", 8'h06);
        check("wr_idle", {31'd0, busy}, 32'd0);

        // ---------------- timeout: read with no ack, TIMEOUT=8
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        n = 0;
        while (wb_cyc === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        check("tmo_cyc_cycles", n, 32'd8);
        check("tmo_stb_low", {31'd0, wb_stb}, 32'd0);
        wait_tx("tmo_nak", 8'h15);
        tick();
        check("tmo_idle", {31'd0, busy}, 32'd0);

        // ---------------- bad opcode then a normal read
        send_byte(8'h41);
        check("bad_no_cyc", {31'd0, wb_cyc}, 32'd0);
        wait_tx("bad_nak", 8'h15);
        check("bad_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        check("bad_rd_cyc", {31'd0, wb_cyc}, 32'd1);
        wb_ack = 1'b1;
        wb_dat_r = 16'h1357;
        tick();
        wb_ack = 1'b0;
        wait_tx("bad_rd_b0", 8'h06);
        wait_tx("bad_rd_b1", 8'h13);
        wait_tx("bad_rd_b2", 8'h57);

        // ---------------- backpressure plus bytes injected during BUS
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("bp_adr", wb_adr, 32'h1234_5678);
        send_byte(8'h41);
        send_byte(8'h57);
        check("bp_adr_kept", wb_adr, 32'h1234_5678);
        check("bp_still_read", {30'd0, wb_cyc, wb_we}, 32'b10);
        tx_busy = 1'b1;
        wb_ack = 1'b1;
        wb_dat_r = 16'hCAFE;
        tick();
        wb_ack = 1'b0;
        count_strobes(20, n);
        check("bp_stalled", n, 32'd0);
        check("bp_busy_held", {31'd0, busy}, 32'd1);
        tx_busy = 1'b0;
        wait_tx("bp_b0", 8'h06);
        wait_tx("bp_b1", 8'hCA);
        wait_tx("bp_b2", 8'hFE);
        count_strobes(8, n);
        check("bp_no_extra", n, 32'd0);
        check("bp_idle", {31'd0, busy}, 32'd0);

        // ---------------- reset during BUS, then a normal write
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        tick();
        check("rst_bus_cyc", {31'd0, wb_cyc}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_bus_ctrl", {27'd0, wb_cyc, wb_stb, wb_we, tx_stb, busy}, 32'd0);
        check("rst_bus_adr", {wb_adr[31:2], wb_sel}, 32'd0);
        rst = 1'b0;
        count_strobes(10, n);
        check("rst_no_tx", n, 32'd0);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
        check("rst_wr_dat", {wb_dat_w, wb_adr[15:0]}, 32'hABCD_0002);
        check("rst_wr_cyc", {30'd0, wb_cyc, wb_we}, 32'b11);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        wait_tx("rst_wr_b0", 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
